// File: rtl/i2c_scl_gen_if.sv
// SCL generator bus bundle: run request and pad readback in, open-drain drive,
// phase strobes and status out. The controller side uses master, the generator uses slave.
interface i2c_scl_gen_if;
    // en is a level request, not a handshake: it is sampled only in IDLE and on the last HIGH cycle.
    logic       en;
    logic       scl_in;
    logic       scl_drive_low;
    logic       tick_fall;
    logic       tick_low_mid;
    logic       tick_rise;
    logic       tick_high_mid;
    logic       stretching;
    logic       stretch_timeout;
    logic       busy;
    logic [1:0] state_dbg;

    modport master (
        output en, scl_in,
        input  scl_drive_low, tick_fall, tick_low_mid, tick_rise, tick_high_mid,
        input  stretching, stretch_timeout, busy, state_dbg
    );

    modport slave (
        input  en, scl_in,
        output scl_drive_low, tick_fall, tick_low_mid, tick_rise, tick_high_mid,
        output stretching, stretch_timeout, busy, state_dbg
    );
endinterface

// File: rtl/i2c_scl_gen.sv
// Programmable I2C SCL generator with open-drain drive, clock-stretch detection,
// optional stretch timeout and mid-phase strobes for the SDA bit engine.
module i2c_scl_gen #(
    parameter int CLK_FREQ_HZ     = 50_000_000,
    parameter int SCL_FREQ_HZ     = 100_000,
    parameter int LOW_PCT         = 50,
    parameter int STRETCH_TIMEOUT = 0
) (
    input logic         clk,
    input logic         rst,
    i2c_scl_gen_if.slave bus
);
    localparam int PERIOD      = CLK_FREQ_HZ / SCL_FREQ_HZ;
    localparam int LOW_CYCLES  = PERIOD * LOW_PCT / 100;
    localparam int HIGH_CYCLES = PERIOD - LOW_CYCLES;
    localparam int MAX_LH      = (LOW_CYCLES > HIGH_CYCLES) ? LOW_CYCLES : HIGH_CYCLES;
    localparam int MAX_ALL     = (MAX_LH > STRETCH_TIMEOUT) ? MAX_LH : STRETCH_TIMEOUT;
    localparam int CNT_W       = $clog2(MAX_ALL + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    // Strobes are registered, so each compare fires one count early to land on the target count.
    localparam cnt_t LOW_MID_PRE  = cnt_t'(LOW_CYCLES / 2 - 1);
    localparam cnt_t LOW_LAST     = cnt_t'(LOW_CYCLES - 1);
    localparam cnt_t HIGH_MID_PRE = cnt_t'(HIGH_CYCLES / 2 - 1);
    localparam cnt_t HIGH_LAST    = cnt_t'(HIGH_CYCLES - 1);
    localparam cnt_t SYNC_PRELOAD = cnt_t'(3);
    localparam cnt_t BUDGET_PRE   = cnt_t'(2);
    localparam cnt_t TIMEOUT_PRE  = cnt_t'((STRETCH_TIMEOUT > 0) ? STRETCH_TIMEOUT - 1 : 0);

    if (LOW_CYCLES < 8 || HIGH_CYCLES < 8) begin : g_bad_timing
        $error("i2c_scl_gen: LOW_CYCLES and HIGH_CYCLES must both be at least 8");
    end

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOW       = 2'd1,
        S_HIGH_WAIT = 2'd2,
        S_HIGH      = 2'd3
    } state_t;

    state_t     state;
    cnt_t       cnt;
    logic [1:0] sync;

    assign bus.state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= S_IDLE;
            cnt                  <= '0;
            sync                 <= 2'b11;
            bus.scl_drive_low    <= 1'b0;
            bus.tick_fall        <= 1'b0;
            bus.tick_low_mid     <= 1'b0;
            bus.tick_rise        <= 1'b0;
            bus.tick_high_mid    <= 1'b0;
            bus.stretching       <= 1'b0;
            bus.stretch_timeout  <= 1'b0;
            bus.busy             <= 1'b0;
        end else begin
            sync                 <= {sync[0], bus.scl_in};
            bus.tick_fall        <= 1'b0;
            bus.tick_low_mid     <= 1'b0;
            bus.tick_rise        <= 1'b0;
            bus.tick_high_mid    <= 1'b0;
            bus.stretch_timeout  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.en) begin
                        state             <= S_LOW;
                        cnt               <= '0;
                        bus.scl_drive_low <= 1'b1;
                        bus.tick_fall     <= 1'b1;
                        bus.busy          <= 1'b1;
                    end
                end
                S_LOW: begin
                    if (cnt == LOW_MID_PRE) bus.tick_low_mid <= 1'b1;
                    if (cnt == LOW_LAST) begin
                        state             <= S_HIGH_WAIT;
                        cnt               <= '0;
                        bus.scl_drive_low <= 1'b0;
                        bus.tick_rise     <= 1'b1;
                    end else begin
                        cnt <= cnt + cnt_t'(1);
                    end
                end
                S_HIGH_WAIT: begin
                    // The preload accounts for the two synchroniser flops plus this decision cycle.
                    if (sync[1]) begin
                        state          <= S_HIGH;
                        cnt            <= SYNC_PRELOAD;
                        bus.stretching <= 1'b0;
                    end else if (STRETCH_TIMEOUT != 0 && cnt == TIMEOUT_PRE) begin
                        state               <= S_IDLE;
                        cnt                 <= '0;
                        bus.stretch_timeout <= 1'b1;
                        bus.stretching      <= 1'b0;
                        bus.busy            <= 1'b0;
                    end else begin
                        if (cnt != '1) cnt <= cnt + cnt_t'(1);
                        if (cnt == BUDGET_PRE) bus.stretching <= 1'b1;
                    end
                end
                S_HIGH: begin
                    if (cnt == HIGH_MID_PRE) bus.tick_high_mid <= 1'b1;
                    if (cnt == HIGH_LAST) begin
                        cnt <= '0;
                        if (bus.en) begin
                            state             <= S_LOW;
                            bus.scl_drive_low <= 1'b1;
                            bus.tick_fall     <= 1'b1;
                        end else begin
                            state    <= S_IDLE;
                            bus.busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + cnt_t'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_scl_gen.sv
// Self-checking bench for i2c_scl_gen: three instances (default, 400k/30%, 200-cycle timeout)
// measured tick-by-tick against a timing table and an arithmetic reference model.
module tb_i2c_scl_gen;
    localparam int CLK_HZ = 50_000_000;
    localparam int A_FREQ = 100_000;
    localparam int A_PCT  = 50;
    localparam int B_FREQ = 400_000;
    localparam int B_PCT  = 30;

    typedef struct {
        int sel;
        int hold;
        int lm;
        int rise;
        int hm;
        int per;
        int str_cyc;
        int str_first;
        int drv;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_a, en_b, en_c;
    logic [1:0] hold_ab;
    logic       hold_c;
    int         stretch_len [2];
    int         hold_left [2];
    int         n_checks = 0;
    int         n_err = 0;

    i2c_scl_gen_if if_a ();
    i2c_scl_gen_if if_b ();
    i2c_scl_gen_if if_c ();

    assign if_a.en     = en_a;
    assign if_b.en     = en_b;
    assign if_c.en     = en_c;
    assign if_a.scl_in = ~if_a.scl_drive_low & ~hold_ab[0];
    assign if_b.scl_in = ~if_b.scl_drive_low & ~hold_ab[1];
    assign if_c.scl_in = ~if_c.scl_drive_low & ~hold_c;

    i2c_scl_gen #(.CLK_FREQ_HZ(CLK_HZ), .SCL_FREQ_HZ(A_FREQ), .LOW_PCT(A_PCT), .STRETCH_TIMEOUT(0))
        u_a (.clk(clk), .rst(rst), .bus(if_a));
    i2c_scl_gen #(.CLK_FREQ_HZ(CLK_HZ), .SCL_FREQ_HZ(B_FREQ), .LOW_PCT(B_PCT), .STRETCH_TIMEOUT(0))
        u_b (.clk(clk), .rst(rst), .bus(if_b));
    i2c_scl_gen #(.CLK_FREQ_HZ(CLK_HZ), .SCL_FREQ_HZ(A_FREQ), .LOW_PCT(A_PCT), .STRETCH_TIMEOUT(200))
        u_c (.clk(clk), .rst(rst), .bus(if_c));

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Bit map: [7]busy [6]stretch_timeout [5]stretching [4]high_mid [3]rise [2]low_mid [1]fall [0]drive_low
    function automatic logic [7:0] sig(input int s);
        case (s)
            0: return {if_a.busy, if_a.stretch_timeout, if_a.stretching, if_a.tick_high_mid,
                       if_a.tick_rise, if_a.tick_low_mid, if_a.tick_fall, if_a.scl_drive_low};
            1: return {if_b.busy, if_b.stretch_timeout, if_b.stretching, if_b.tick_high_mid,
                       if_b.tick_rise, if_b.tick_low_mid, if_b.tick_fall, if_b.scl_drive_low};
            default: return {if_c.busy, if_c.stretch_timeout, if_c.stretching, if_c.tick_high_mid,
                             if_c.tick_rise, if_c.tick_low_mid, if_c.tick_fall, if_c.scl_drive_low};
        endcase
    endfunction

    function automatic int st(input int s);
        case (s)
            0:       return int'(if_a.state_dbg);
            1:       return int'(if_b.state_dbg);
            default: return int'(if_c.state_dbg);
        endcase
    endfunction

    // Emulated slave: after each tick_rise, keep SCL low for stretch_len sampled clock edges.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [7:0] b;
            b = sig(i);
            if (hold_left[i] > 0) begin
                hold_left[i]--;
                if (hold_left[i] == 0) hold_ab[i] = 1'b0;
            end else if (b[3] && stretch_len[i] > 0) begin
                hold_ab[i]   = 1'b1;
                hold_left[i] = stretch_len[i];
            end
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_tick(input int s, input int bitn, input string name);
        logic [7:0] b;
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            b = sig(s);
            if (b[bitn]) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, int'(seen), 1);
    endtask

    // Reference model: phase timing straight from the frequency/duty arithmetic.
    // A hold of h edges after the rise extends the high phase by h, and stretching
    // is shown from 3 cycles after the rise for exactly h cycles.
    function automatic vec_t model(input int sel, input int h);
        vec_t r;
        int period, low, high;
        period      = CLK_HZ / ((sel == 0) ? A_FREQ : B_FREQ);
        low         = period * ((sel == 0) ? A_PCT : B_PCT) / 100;
        high        = period - low;
        r.sel       = sel;
        r.hold      = h;
        r.lm        = low / 2;
        r.rise      = low;
        r.hm        = low + h + high / 2;
        r.per       = low + high + h;
        r.str_cyc   = h;
        r.str_first = (h > 0) ? low + 3 : -1;
        r.drv       = low;
        return r;
    endfunction

    // Offsets are in clock cycles from a tick_fall to the events of that one SCL period.
    task automatic measure(input int s, output vec_t r);
        logic [7:0] b;
        bit done;
        r = '{sel: s, hold: stretch_len[s], lm: -1, rise: -1, hm: -1, per: -1,
              str_cyc: 0, str_first: -1, drv: 1};
        wait_tick(s, 1, "wait_fall");
        done = 1'b0;
        for (int t = 1; t < 5000; t++) begin
            @(negedge clk);
            b = sig(s);
            if (b[1]) begin
                r.per = t;
                done  = 1'b1;
                break;
            end
            if (b[0]) r.drv++;
            if (b[2] && r.lm < 0) r.lm = t;
            if (b[3] && r.rise < 0) r.rise = t;
            if (b[4] && r.hm < 0) r.hm = t;
            if (b[5]) begin
                r.str_cyc++;
                if (r.str_first < 0) r.str_first = t;
            end
        end
        check("period_end", int'(done), 1);
    endtask

    task automatic compare(input string tag, input vec_t got, input vec_t exp);
        check($sformatf("%s_low_mid", tag), got.lm, exp.lm);
        check($sformatf("%s_rise", tag), got.rise, exp.rise);
        check($sformatf("%s_high_mid", tag), got.hm, exp.hm);
        check($sformatf("%s_period", tag), got.per, exp.per);
        check($sformatf("%s_stretch_cycles", tag), got.str_cyc, exp.str_cyc);
        check($sformatf("%s_stretch_first", tag), got.str_first, exp.str_first);
        check($sformatf("%s_drive_cycles", tag), got.drv, exp.drv);
    endtask

    // ---------------- stimulus ----------------
    vec_t tbl [6];

    initial begin
        vec_t got, exp;
        logic [7:0] b;
        int busy_end, falls, rise_at, to_t, sf;

        tbl[0] = '{sel: 0, hold: 0,    lm: 125, rise: 250, hm: 375,  per: 500,  str_cyc: 0,    str_first: -1,  drv: 250};
        tbl[1] = '{sel: 1, hold: 0,    lm: 18,  rise: 37,  hm: 81,   per: 125,  str_cyc: 0,    str_first: -1,  drv: 37};
        tbl[2] = '{sel: 0, hold: 1000, lm: 125, rise: 250, hm: 1375, per: 1500, str_cyc: 1000, str_first: 253, drv: 250};
        tbl[3] = '{sel: 0, hold: 1,    lm: 125, rise: 250, hm: 376,  per: 501,  str_cyc: 1,    str_first: 253, drv: 250};
        tbl[4] = '{sel: 1, hold: 5,    lm: 18,  rise: 37,  hm: 86,   per: 130,  str_cyc: 5,    str_first: 40,  drv: 37};
        tbl[5] = '{sel: 0, hold: 40,   lm: 125, rise: 250, hm: 415,  per: 540,  str_cyc: 40,   str_first: 253, drv: 250};

        rst            = 1'b1;
        en_a           = 1'b0;
        en_b           = 1'b0;
        en_c           = 1'b0;
        hold_ab        = 2'b00;
        hold_c         = 1'b0;
        stretch_len[0] = 0;
        stretch_len[1] = 0;
        hold_left[0]   = 0;
        hold_left[1]   = 0;
        repeat (4) @(negedge clk);

        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset_outputs_%0d", s), int'(sig(s)), 0);
            check($sformatf("reset_state_%0d", s), st(s), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("idle_without_en", int'(sig(0)), 0);

        en_a = 1'b1;
        en_b = 1'b1;
        @(negedge clk);
        check("first_fall_a", int'(sig(0)), 8'h83);
        check("first_fall_b", int'(sig(1)), 8'h83);

        for (int i = 0; i < 6; i++) begin
            stretch_len[tbl[i].sel] = tbl[i].hold;
            measure(tbl[i].sel, got);
            compare($sformatf("vec%0d", i), got, tbl[i]);
        end
        stretch_len[0] = 0;
        stretch_len[1] = 0;

        for (int i = 0; i < 8; i++) begin
            int s, h;
            s = int'($urandom_range(0, 1));
            h = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 300));
            stretch_len[s] = h;
            measure(s, got);
            exp = model(s, h);
            compare($sformatf("rnd%0d_sel%0d_hold%0d", i, s, h), got, exp);
            stretch_len[s] = 0;
        end

        // en dropped early in LOW: the period finishes, then the generator parks in IDLE.
        wait_tick(0, 1, "drop_wait_fall");
        busy_end = -1;
        falls    = 0;
        rise_at  = -1;
        for (int k = 1; k <= 1200; k++) begin
            @(negedge clk);
            if (k == 10) en_a = 1'b0;
            b = sig(0);
            if (b[1]) falls++;
            if (b[3] && rise_at < 0) rise_at = k;
            if (!b[7] && busy_end < 0) busy_end = k;
        end
        check("drop_rise_at", rise_at, 250);
        check("drop_busy_len", busy_end, 500);
        check("drop_no_fall", falls, 0);
        check("drop_idle_outputs", int'(sig(0)), 0);
        check("drop_idle_state", st(0), 0);

        // One-cycle reset in the middle of LOW.
        en_a = 1'b1;
        wait_tick(0, 1, "rst_wait_fall");
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_low_outputs", int'(sig(0)), 0);
        check("rst_mid_low_state", st(0), 0);
        @(negedge clk);
        check("fall_after_rst", int'(sig(0)), 8'h83);

        // Slave holds SCL low until the 200-cycle timeout fires.
        en_c = 1'b1;
        wait_tick(2, 1, "to_wait_fall");
        hold_c = 1'b1;
        en_c   = 1'b0;
        wait_tick(2, 3, "to_wait_rise");
        to_t = -1;
        sf   = -1;
        b    = '0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            b = sig(2);
            if (b[5] && sf < 0) sf = k;
            if (b[6]) begin
                to_t = k;
                break;
            end
        end
        check("timeout_at", to_t, 200);
        check("timeout_stretch_first", sf, 3);
        check("timeout_pulse_outputs", int'(b), 8'h40);
        @(negedge clk);
        check("after_timeout_outputs", int'(sig(2)), 0);
        check("after_timeout_state", st(2), 0);
        hold_c = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
